// File: rtl/mips_pipeline_pkg.sv
// Shared types for the MIPS pipeline MEM stage.
// Holds the MEM FSM state enum and the MEM/WB bundle.
package mips_pipeline_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic                      selMem;
      logic [DATA_WIDTH-1:0]     dataRead;
      logic [DATA_WIDTH-1:0]     resultALU;
      logic                      enWrite;
      logic [REG_ADDR_WIDTH-1:0] addrWrite;
   } mem_wb_bundle_t;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register feeding write-back.
// Ports: clk, reset (sync, low), load_i, bubble_i, d_i -> q_o.
module mem_wb_register
   import mips_pipeline_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           load_i,
   input  logic           bubble_i,
   input  mem_wb_bundle_t d_i,
   output mem_wb_bundle_t q_o
);

   mem_wb_bundle_t q_q;

   // A bubble clears the whole slot, so WB sees a clean no-op.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q <= '0;
      end else if (bubble_i) begin
         q_q <= '0;
      end else if (load_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: word loads/stores on a variable-latency data memory.
// Ports: EX/MEM bundle in, data-memory req/ready, stall, MEM/WB outputs.
module memory_access_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      validInstruction_Execute,
   input  logic [DATA_WIDTH-1:0]     resultALU_Execute,
   input  logic [DATA_WIDTH-1:0]     dataWrite_Execute,
   input  logic                      controlSignalReadDataMemory_Execute,
   input  logic                      controlSignalWriteDataMemory_Execute,
   input  logic                      controlSignalWriteFromDataMemoryRegisterFile_Execute,
   input  logic                      enableWriteRegisterFile_Execute,
   input  logic [REG_ADDR_WIDTH-1:0] addressWriteRegisterFile_Execute,
   output logic                      memRequest_DataMemory,
   output logic                      memWrite_DataMemory,
   output logic [ADDR_WIDTH-1:0]     memAddress_DataMemory,
   output logic [DATA_WIDTH-1:0]     memWriteData_DataMemory,
   input  logic                      memReady_DataMemory,
   input  logic [DATA_WIDTH-1:0]     memReadData_DataMemory,
   output logic                      stall_MemoryAccess,
   output logic                      alignmentError_MemoryAccess,
   output logic                      controlSignalWriteFromDataMemoryRegisterFile_MemoryAccess,
   output logic [DATA_WIDTH-1:0]     dataReadDataMemory_MemoryAccess,
   output logic [DATA_WIDTH-1:0]     resultALU_MemoryAccess,
   output logic                      enableWriteRegisterFile_MemoryAccess,
   output logic [REG_ADDR_WIDTH-1:0] addressWriteRegisterFile_MemoryAccess
);

   import mips_pipeline_pkg::*;

   mem_state_t state_q, state_d;

   logic memOp;
   logic aligned;
   logic inIdle;
   logic inWait;

   logic                      reqWrite_q;
   logic [ADDR_WIDTH-1:0]     reqAddr_q;
   logic [DATA_WIDTH-1:0]     reqData_q;
   logic [DATA_WIDTH-1:0]     reqAlu_q;
   logic                      reqSel_q;
   logic                      reqEn_q;
   logic [REG_ADDR_WIDTH-1:0] reqRd_q;

   logic alignErr_q, alignErr_d;
   logic issue;
   logic wbLoad;
   mem_wb_bundle_t wbD;
   mem_wb_bundle_t wbQ;

   assign memOp   = validInstruction_Execute &
                    (controlSignalReadDataMemory_Execute |
                     controlSignalWriteDataMemory_Execute);
   assign aligned = (resultALU_Execute[1:0] == 2'b00);
   assign inIdle  = (state_q == IDLE);
   assign inWait  = (state_q == WAIT);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (memOp && aligned) state_d = WAIT;
         WAIT: if (memReady_DataMemory) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath control
   always_comb begin
      issue      = 1'b0;
      wbLoad     = 1'b0;
      alignErr_d = 1'b0;
      wbD        = '0;
      unique case (state_q)
         IDLE: begin
            unique case (1'b1)
               !memOp: begin
                  wbLoad        = 1'b1;
                  wbD.selMem    = controlSignalWriteFromDataMemoryRegisterFile_Execute;
                  wbD.resultALU = resultALU_Execute;
                  wbD.enWrite   = enableWriteRegisterFile_Execute &
                                  validInstruction_Execute;
                  wbD.addrWrite = addressWriteRegisterFile_Execute;
               end
               (memOp && !aligned): alignErr_d = 1'b1;
               (memOp && aligned):  issue = 1'b1;
               default: ;
            endcase
         end
         WAIT: begin
            if (memReady_DataMemory) begin
               wbLoad        = 1'b1;
               wbD.selMem    = reqSel_q;
               wbD.dataRead  = reqWrite_q ? '0 : memReadData_DataMemory;
               wbD.resultALU = reqAlu_q;
               wbD.enWrite   = reqEn_q;
               wbD.addrWrite = reqRd_q;
            end
         end
         default: ;
      endcase
   end

   // Request registers: captured once at issue, stable through WAIT.
   // A read+write combination is issued as a store.
   always_ff @(posedge clk) begin
      if (!reset) begin
         reqWrite_q <= 1'b0;
         reqAddr_q  <= '0;
         reqData_q  <= '0;
         reqAlu_q   <= '0;
         reqSel_q   <= 1'b0;
         reqEn_q    <= 1'b0;
         reqRd_q    <= '0;
      end else if (issue) begin
         reqWrite_q <= controlSignalWriteDataMemory_Execute;
         reqAddr_q  <= resultALU_Execute[ADDR_WIDTH-1:0];
         reqData_q  <= dataWrite_Execute;
         reqAlu_q   <= resultALU_Execute;
         reqSel_q   <= controlSignalWriteFromDataMemoryRegisterFile_Execute;
         reqEn_q    <= enableWriteRegisterFile_Execute;
         reqRd_q    <= addressWriteRegisterFile_Execute;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         alignErr_q <= 1'b0;
      end else begin
         alignErr_q <= alignErr_d;
      end
   end

   mem_wb_register u_mem_wb (
      .clk      (clk),
      .reset    (reset),
      .load_i   (wbLoad),
      .bubble_i (!wbLoad),
      .d_i      (wbD),
      .q_o      (wbQ)
   );

   // Memory interface is quiet outside WAIT.
   assign memRequest_DataMemory   = inWait;
   assign memWrite_DataMemory     = inWait & reqWrite_q;
   assign memAddress_DataMemory   = inWait ? reqAddr_q : '0;
   assign memWriteData_DataMemory = inWait ? reqData_q : '0;

   assign stall_MemoryAccess = (inIdle & memOp & aligned) |
                               (inWait & !memReady_DataMemory);

   assign alignmentError_MemoryAccess = alignErr_q;

   assign controlSignalWriteFromDataMemoryRegisterFile_MemoryAccess = wbQ.selMem;
   assign dataReadDataMemory_MemoryAccess       = wbQ.dataRead;
   assign resultALU_MemoryAccess                = wbQ.resultALU;
   assign enableWriteRegisterFile_MemoryAccess  = wbQ.enWrite;
   assign addressWriteRegisterFile_MemoryAccess = wbQ.addrWrite;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a WB scoreboard.
// Drives EX/MEM, models memory ready/data, checks WB order/latency.
module tb_memory_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic [31:0] alu;
   logic [31:0] wdata;
   logic        rdCtl;
   logic        wrCtl;
   logic        selCtl;
   logic        enCtl;
   logic [4:0]  rdAddr;
   logic        memReq;
   logic        memWr;
   logic [31:0] memAddr;
   logic [31:0] memWData;
   logic        memReady;
   logic [31:0] memRData;
   logic        stall;
   logic        alignErr;
   logic        wbSel;
   logic [31:0] wbData;
   logic [31:0] wbAlu;
   logic        wbEn;
   logic [4:0]  wbRd;

   always #5 clk = ~clk;

   memory_access_stage dut (
      .clk                                  (clk),
      .reset                                (reset),
      .validInstruction_Execute             (valid),
      .resultALU_Execute                    (alu),
      .dataWrite_Execute                    (wdata),
      .controlSignalReadDataMemory_Execute  (rdCtl),
      .controlSignalWriteDataMemory_Execute (wrCtl),
      .controlSignalWriteFromDataMemoryRegisterFile_Execute (selCtl),
      .enableWriteRegisterFile_Execute      (enCtl),
      .addressWriteRegisterFile_Execute     (rdAddr),
      .memRequest_DataMemory                (memReq),
      .memWrite_DataMemory                  (memWr),
      .memAddress_DataMemory                (memAddr),
      .memWriteData_DataMemory              (memWData),
      .memReady_DataMemory                  (memReady),
      .memReadData_DataMemory               (memRData),
      .stall_MemoryAccess                   (stall),
      .alignmentError_MemoryAccess          (alignErr),
      .controlSignalWriteFromDataMemoryRegisterFile_MemoryAccess (wbSel),
      .dataReadDataMemory_MemoryAccess      (wbData),
      .resultALU_MemoryAccess               (wbAlu),
      .enableWriteRegisterFile_MemoryAccess (wbEn),
      .addressWriteRegisterFile_MemoryAccess(wbRd)
   );

   typedef struct {
      logic        sel;
      logic [31:0] data;
      logic [31:0] alu;
      logic        en;
      logic [4:0]  rd;
      int          cyc;
   } wb_exp_t;

   wb_exp_t sb[$];
   int cyc    = 0;
   int tests  = 0;
   int fails  = 0;
   int issues = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_wb(input logic s, input logic [31:0] d,
                            input logic [31:0] a, input logic e,
                            input logic [4:0] r, input int lat);
      wb_exp_t x;
      x.sel = s; x.data = d; x.alu = a;
      x.en = e; x.rd = r; x.cyc = cyc + lat;
      sb.push_back(x);
   endtask

   // A retired WB slot always carries a nonzero address/result here;
   // bubbles and idle slots are all-zero.
   task automatic monitor();
      wb_exp_t e;
      if (wbAlu !== 32'h0) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected", wbAlu, 32'h0);
         end else begin
            e = sb.pop_front();
            chk("wb_cycle", 32'(cyc), 32'(e.cyc));
            chk("wb_sel", 32'(wbSel), 32'(e.sel));
            chk("wb_data", wbData, e.data);
            chk("wb_alu", wbAlu, e.alu);
            chk("wb_en", 32'(wbEn), 32'(e.en));
            chk("wb_rd", 32'(wbRd), 32'(e.rd));
         end
      end
   endtask

   task automatic step();
      if (memReq && memReady) issues++;
      @(posedge clk);
      #1;
      cyc++;
      monitor();
   endtask

   task automatic drive(input logic v, input logic r, input logic w,
                        input logic s, input logic e, input logic [4:0] d,
                        input logic [31:0] a, input logic [31:0] wd);
      valid = v; rdCtl = r; wrCtl = w; selCtl = s;
      enCtl = e; rdAddr = d; alu = a; wdata = wd;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
   endtask

   initial begin
      reset    = 1'b0;
      memReady = 1'b0;
      memRData = 32'h0;
      idle();
      step();
      step();
      chk("rst_req", 32'(memReq), 32'h0);
      chk("rst_addr", memAddr, 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_wb_en", 32'(wbEn), 32'h0);
      chk("rst_wb_alu", wbAlu, 32'h0);
      chk("rst_align", 32'(alignErr), 32'h0);
      reset = 1'b1;
      step();

      // ALU op
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h10, 32'h0);
      expect_wb(1'b0, 32'h0, 32'h10, 1'b1, 5'd5, 1);
      chk("alu_stall", 32'(stall), 32'h0);
      chk("alu_req", 32'(memReq), 32'h0);
      step();
      idle();
      step();

      // Load, ready on third WAIT cycle
      memReady = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'hAAAA);
      expect_wb(1'b1, 32'hDEADBEEF, 32'h100, 1'b1, 5'd7, 4);
      chk("ld_stall_idle", 32'(stall), 32'h1);
      chk("ld_req_idle", 32'(memReq), 32'h0);
      step();
      chk("ld_req_w1", 32'(memReq), 32'h1);
      chk("ld_wr_w1", 32'(memWr), 32'h0);
      chk("ld_addr_w1", memAddr, 32'h100);
      chk("ld_stall_w1", 32'(stall), 32'h1);
      step();
      chk("ld_addr_w2", memAddr, 32'h100);
      chk("ld_stall_w2", 32'(stall), 32'h1);
      step();
      memReady = 1'b1;
      memRData = 32'hDEADBEEF;
      #1;
      chk("ld_req_w3", 32'(memReq), 32'h1);
      chk("ld_stall_w3", 32'(stall), 32'h0);
      idle();
      step();
      memReady = 1'b0;
      memRData = 32'h0;
      #1;
      chk("ld_req_done", 32'(memReq), 32'h0);
      step();

      // Store, ready on first WAIT cycle
      memReady = 1'b1;
      memRData = 32'hFFFFFFFF;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h204, 32'h12345678);
      expect_wb(1'b0, 32'h0, 32'h204, 1'b0, 5'd0, 2);
      chk("st_stall_idle", 32'(stall), 32'h1);
      chk("st_req_idle", 32'(memReq), 32'h0);
      step();
      chk("st_req", 32'(memReq), 32'h1);
      chk("st_wr", 32'(memWr), 32'h1);
      chk("st_addr", memAddr, 32'h204);
      chk("st_wdata", memWData, 32'h12345678);
      chk("st_stall", 32'(stall), 32'h0);
      idle();
      step();
      chk("st_req_done", 32'(memReq), 32'h0);
      chk("st_wdata_done", memWData, 32'h0);

      // Read and write both set acts as a store
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 32'h208, 32'h0BADF00D);
      expect_wb(1'b1, 32'h0, 32'h208, 1'b1, 5'd6, 2);
      step();
      chk("rw_wr", 32'(memWr), 32'h1);
      chk("rw_wdata", memWData, 32'h0BADF00D);
      idle();
      step();
      memReady = 1'b0;

      // Misaligned load
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h102, 32'h0);
      chk("mis_stall", 32'(stall), 32'h0);
      step();
      chk("mis_align", 32'(alignErr), 32'h1);
      chk("mis_req", 32'(memReq), 32'h0);
      chk("mis_wb_en", 32'(wbEn), 32'h0);
      idle();
      step();
      chk("mis_align_pulse", 32'(alignErr), 32'h0);

      // Back-to-back load then ALU op
      issues = 0;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h100, 32'h0);
      expect_wb(1'b1, 32'hCAFEF00D, 32'h100, 1'b1, 5'd8, 2);
      step();
      memReady = 1'b1;
      memRData = 32'hCAFEF00D;
      step();
      memReady = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h30, 32'h0);
      expect_wb(1'b0, 32'h0, 32'h30, 1'b1, 5'd9, 1);
      chk("b2b_alu_req", 32'(memReq), 32'h0);
      step();
      idle();
      step();
      chk("b2b_issues", 32'(issues), 32'h1);

      // Reset while in WAIT
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h100, 32'h0);
      step();
      chk("rw_req_wait", 32'(memReq), 32'h1);
      reset = 1'b0;
      idle();
      step();
      chk("rwait_req", 32'(memReq), 32'h0);
      chk("rwait_addr", memAddr, 32'h0);
      chk("rwait_stall", 32'(stall), 32'h0);
      chk("rwait_wb_sel", 32'(wbSel), 32'h0);
      chk("rwait_wb_en", 32'(wbEn), 32'h0);
      chk("rwait_wb_rd", 32'(wbRd), 32'h0);
      reset = 1'b1;
      memReady = 1'b1;
      memRData = 32'h55AA55AA;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h108, 32'h0);
      expect_wb(1'b1, 32'h55AA55AA, 32'h108, 1'b1, 5'd3, 2);
      step();
      chk("post_rst_addr", memAddr, 32'h108);
      idle();
      step();
      memReady = 1'b0;
      step();

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
